uart_tx_fifo: RTL and testbench

- General-purpose UART transmitter with a byte-stream valid/ready input buffered by a small FIFO.
- Complements the board's existing UART receive path, which delivers one byte plus a ready flag. This block lets any producer (echo logic, status reporter, memory dump) push arbitrary bytes out of the board's tx pin.
- Format: 8N1, LSB first, idle-high line, bit period of DELAY_FRAMES clocks. Targets the 27 MHz board clock.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- byte-stream handshake between a producer and the UART
// transmitter FIFO.
//
//   data_in    : byte offered by the producer
//   data_valid : producer offers data_in this cycle
//   data_ready : FIFO can accept a byte this cycle
//
// A byte is transferred on a clk edge where data_valid && data_ready.
// master = producer side, slave = FIFO side.
interface uart_tx_fifo_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter (LSB first, idle-high line) fed by a small
// byte FIFO. Each bit lasts DELAY_FRAMES clocks; back-to-back frames are sent
// without an idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   undefined : 8N1 frame, 10*DELAY_FRAMES clocks
//   defined   : 8E1 frame, an even-parity bit between data and stop,
//               11*DELAY_FRAMES clocks
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high; aborts any frame, empties FIFO
//   in_if      : slave side of the byte handshake (data_in/data_valid/data_ready)
//   uart_tx    : serial line, registered
//   busy       : a frame is on the line or the FIFO holds bytes
//   fifo_count : bytes buffered, not counting the byte being shifted out
//
// Parameters:
//   DELAY_FRAMES : clocks per bit, >= 2 (234 = 27 MHz / 115200)
//   FIFO_DEPTH   : FIFO entries, power of two, >= 2
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (0) on the line
// DATA   | data bit bit_idx_q on the line
// PARITY | even parity of the byte on the line (parity build only)
// STOP   | stop bit (1) on the line
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 in_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BIT_LAST  = 16'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  assign in_if.data_ready = (count_q < DEPTH_C);
  assign push             = in_if.data_valid && in_if.data_ready;
  assign fifo_count       = count_q;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two; full and
  // empty are told apart by count_q, never by pointer equality.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= in_if.data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        tx_q, tx_d;
  logic        bit_done;
  logic        fifo_nonempty;

  assign bit_done      = (bit_cnt_q == BIT_LAST);
  assign fifo_nonempty = (count_q != '0);

  // State register (also holds the FIFO bookkeeping and the line register).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. The pop decision looks at count_q (pre-push), so a byte
  // pushed on the same edge is only seen one cycle later.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          byte_d    = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            byte_d  = mem_q[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Output logic. The line level is derived from the next state so that the
  // registered uart_tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = byte_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^byte_d;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;
  assign busy    = (state_q != ST_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DELAY_FRAMES=4, FIFO_DEPTH=4). A byte-queue model
// predicts the line level cycle by cycle from frame start time and byte value.
module tb_uart_tx_fifo;

  localparam int DF = 4;
  localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DF;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .DELAY_FRAMES (DF),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queued bytes, and the frame currently on the line.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Line level at offset m_pos into the frame: slot 0 start, slots 1..8 data
  // LSB first, then optional parity, then stop.
  function automatic logic exp_line();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / DF;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit accept;
    bit take;
    @(negedge clk);
    bus.data_valid = v;
    bus.data_in    = d;
    rst            = r;
    accept = !r && v && (m_q.size() < FD);
    take   = !r && (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      if (take) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (accept) m_q.push_back(d);
    end
    #1;
    check("uart_tx",    32'(uart_tx),    32'(exp_line()));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("busy",       32'(busy),       32'(m_active || m_q.size() != 0));
    check("data_ready", 32'(bus.data_ready), 32'(m_q.size() < FD));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int rate;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    rst            = 1'b1;

    // Reset state
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(7);

    // Single byte
    step(1'b1, 8'h55, 1'b0);
    idle(FRAME + 10);

    // Back-to-back
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    idle(2 * FRAME + 10);

    // Full FIFO: a new byte offered every cycle regardless of data_ready
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
    idle(6 * FRAME);

    // Push exactly on the stop-bit expiry edge with one byte buffered
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == FRAME - 1); i++) idle(1);
    step(1'b1, 8'h33, 1'b0);
    idle(3 * FRAME);

    // Reset during data bit 3 of 0xA5 with two bytes buffered
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    for (int i = 0; i < FRAME && !(m_active && m_pos == 4 * DF + 1); i++) idle(1);
    step(1'b0, 8'h00, 1'b1);
    idle(FRAME + 5);

`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07, 1'b0);
    idle(FRAME + 4);
    step(1'b1, 8'h03, 1'b0);
    idle(FRAME + 4);
`endif

    // Randomized traffic with varying load and occasional resets
    rate = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(0, 2) == 0 ? 3 : ($urandom_range(0, 1) == 0 ? 15 : 60);
      step($urandom_range(0, 99) < rate, 8'($urandom), $urandom_range(0, 799) == 0);
    end

    // Drain
    for (int i = 0; i < (FD + 2) * FRAME && (m_active || m_q.size() != 0); i++) idle(1);
    idle(2);
    check("final_busy", 32'(busy), 32'd0);
    check("final_tx",   32'(uart_tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
